// File: rtl/rx_cgs_if.sv
// Lane decoder / CGS controller bundle: decoded character stream in,
// SYNC~ request and phase status out.
interface rx_cgs_if;
    logic       dec_valid;
    logic [7:0] dec_data;
    logic       dec_is_k;
    logic       dec_disp_err;
    logic       dec_nit_err;
    logic       lmfc_tick;
    logic       sync_n;
    logic [1:0] cgs_state;
    logic       ilas_start;
    logic       data_phase;
    logic       resync_pulse;

    modport master (
        output dec_valid, dec_data, dec_is_k,
        output dec_disp_err, dec_nit_err, lmfc_tick,
        input  sync_n, cgs_state, ilas_start,
        input  data_phase, resync_pulse
    );

    modport slave (
        input  dec_valid, dec_data, dec_is_k,
        input  dec_disp_err, dec_nit_err, lmfc_tick,
        output sync_n, cgs_state, ilas_start,
        output data_phase, resync_pulse
    );
endinterface

// File: rtl/rx_cgs_ctrl.sv
// JESD204B per-lane CGS / ILAS / data phase sequencer.
// Optional RX_CGS_LMFC_ALIGN_EN: leave CS_INIT only on an lmfc_tick cycle.
module rx_cgs_ctrl #(
    parameter int K_CNT_REQ    = 4,
    parameter int ERR_THRESH   = 3,
    parameter int GOOD_CLR     = 4,
    parameter int SYNC_MIN_LOW = 4
) (
    input  logic     clk,
    input  logic     rst,
    rx_cgs_if.slave  bus
);
    localparam int CW = 8;

    typedef enum logic [1:0] {
        CS_INIT  = 2'd0,
        CS_CHECK = 2'd1,
        CS_DATA  = 2'd2
    } cgs_e;

    cgs_e          state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] low_q, low_d;
    logic [CW-1:0] err_q, err_d;
    logic [CW-1:0] good_q, good_d;
    logic          sync_n_q, ilas_q, data_q, resync_q;
    logic          ilas_d, resync_d;

    logic inv_ch, good_ch, k28_5, k28_0, lmfc_ok;

    assign inv_ch  = bus.dec_valid
                   & (bus.dec_disp_err | bus.dec_nit_err);
    assign good_ch = bus.dec_valid
                   & ~bus.dec_disp_err & ~bus.dec_nit_err;
    assign k28_5   = good_ch & bus.dec_is_k
                   & (bus.dec_data == 8'hBC);
    assign k28_0   = good_ch & bus.dec_is_k
                   & (bus.dec_data == 8'h1C);

`ifdef RX_CGS_LMFC_ALIGN_EN
    assign lmfc_ok = bus.lmfc_tick;
`else
    assign lmfc_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        low_d    = low_q;
        err_d    = err_q;
        good_d   = good_q;
        ilas_d   = 1'b0;
        resync_d = 1'b0;
        unique case (state_q)
            CS_INIT: begin
                // SYNC~ low time counts raw clocks, not characters
                if (low_q < CW'(SYNC_MIN_LOW))
                    low_d = low_q + 1'b1;
                if (bus.dec_valid) begin
                    if (!k28_5)
                        k_d = '0;
                    else if (k_q < CW'(K_CNT_REQ))
                        k_d = k_q + 1'b1;
                end
                if (k_d >= CW'(K_CNT_REQ) &&
                    low_d >= CW'(SYNC_MIN_LOW) && lmfc_ok) begin
                    state_d = CS_CHECK;
                    k_d     = '0;
                    low_d   = '0;
                    err_d   = '0;
                    good_d  = '0;
                end
            end
            CS_CHECK, CS_DATA: begin
                if (inv_ch) begin
                    err_d  = err_q + 1'b1;
                    good_d = '0;
                    if (err_d >= CW'(ERR_THRESH)) begin
                        state_d  = CS_INIT;
                        resync_d = 1'b1;
                        k_d      = '0;
                        low_d    = '0;
                        err_d    = '0;
                        good_d   = '0;
                    end
                end else if (good_ch) begin
                    good_d = good_q + 1'b1;
                    if (good_d >= CW'(GOOD_CLR)) begin
                        err_d  = '0;
                        good_d = '0;
                    end
                    if (state_q == CS_CHECK && !k28_5) begin
                        state_d = CS_DATA;
                        ilas_d  = k28_0;
                    end
                end
            end
            default: begin
                state_d = CS_INIT;
                k_d     = '0;
                low_d   = '0;
                err_d   = '0;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CS_INIT;
            k_q      <= '0;
            low_q    <= '0;
            err_q    <= '0;
            good_q   <= '0;
            sync_n_q <= 1'b0;
            ilas_q   <= 1'b0;
            data_q   <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            low_q    <= low_d;
            err_q    <= err_d;
            good_q   <= good_d;
            sync_n_q <= (state_d != CS_INIT);
            ilas_q   <= ilas_d;
            data_q   <= (state_d == CS_DATA);
            resync_q <= resync_d;
        end
    end

    assign bus.sync_n       = sync_n_q;
    assign bus.cgs_state    = state_q;
    assign bus.ilas_start   = ilas_q;
    assign bus.data_phase   = data_q;
    assign bus.resync_pulse = resync_q;
endmodule
